multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the 16-bit multicycle CPU; upstream driver of AluOp into ALU control.
//  Decodes Opcode = IR[15:12] and sequences fetch/decode/execute/memory/writeback states.
//  Drives datapath mux selects, write enables, and a request/ready handshake to unified memory.
//  AluOp: 00 = add (ALU code 0100), 01 = sub/compare (1100), 10 = R-type, use Func.
// PARAMETERS
//  OPW        4   opcode width (IR[15:12])
//  PC_INC_SEL 2'b01 AluSrcB select for PC increment constant in FETCH
// PORTS
//  Clock       in  1  single system clock, rising edge
//  Reset       in  1  synchronous, active-high
//  Opcode      in  4  IR[15:12], valid from DECODE onward
//  Zero        in  1  ALU zero flag, sampled in BRANCH
//  MemReady    in  1  memory done; read data valid / write accepted this cycle
//  MemRead     out 1  memory read request, held until MemReady
//  MemWrite    out 1  memory write request, held until MemReady
//  IorD        out 1  0 = PC address, 1 = ALUOut address
//  IRWrite     out 1  load IR
//  PCWrite     out 1  unconditional PC load
//  PCWriteCond out 1  PC load if Zero
//  PCSource    out 2  00 ALU result, 01 ALUOut, 10 jump target
//  AluSrcA     out 1  0 = PC, 1 = RegA
//  AluSrcB     out 2  00 RegB, 01 constant, 10 sign-ext imm, 11 sign-ext branch offset
//  AluOp       out 2  to ALU control, encoding above
//  RegDst      out 1  0 = rt, 1 = rd
//  MemToReg    out 1  0 = ALUOut, 1 = MDR
//  RegWrite    out 1  register file write enable
//  Halt        out 1  high in HALT state
//  State       out 4  current state code, debug
// BEHAVIOUR
//  - Reset high at edge -> state IDLE; all outputs 0 while in IDLE; IDLE -> FETCH next cycle.
//  - Reset is honoured in every state, including mid-memory wait; MemRead/MemWrite drop on the next edge.
//  - Outputs are Moore from State, except IRWrite and PCWrite in FETCH, which = MemReady (Mealy).
//  - FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=PC_INC_SEL, AluOp=00, PCSource=00.
//    Waits while MemReady=0; on MemReady: IRWrite=1, PCWrite=1 -> DECODE.
//  - DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (branch target to ALUOut). Dispatch on Opcode:
//    0000 R -> EXEC_R; 0100 LW, 0101 SW -> MEM_ADDR; 0110 ADDI -> ADDI_EX;
//    1000 BEQ -> BRANCH; 1010 J -> JUMP; any other -> HALT.
//  - EXEC_R: AluSrcA=1, AluSrcB=00, AluOp=10 -> R_WB (RegWrite=1, RegDst=1, MemToReg=0) -> FETCH.
//  - MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=00 -> MEM_RD (LW) or MEM_WR (SW).
//  - MEM_RD: MemRead=1, IorD=1; waits on MemReady -> MEM_WB (RegWrite=1, RegDst=0, MemToReg=1) -> FETCH.
//  - MEM_WR: MemWrite=1, IorD=1; waits on MemReady -> FETCH.
//  - ADDI_EX: AluSrcA=1, AluSrcB=10, AluOp=00 -> ADDI_WB (RegWrite=1, RegDst=0, MemToReg=0) -> FETCH.
//  - BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
//  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
//  - HALT: Halt=1, all enables 0; left only by Reset.
//  - Zero-wait memory (MemReady already high on request cycle) completes in that same cycle.
//    MemReady outside FETCH/MEM_RD/MEM_WR is ignored.
//  - MemRead and MemWrite are never both high. RegWrite is never high in a memory-wait cycle.
//  - Cycle counts, zero-wait memory: R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3.
//  - Undefined state codes recover to IDLE.
// STRUCTURE
//  - Shared include cpu_defs.vh: opcode localparams (OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J),
//    AluOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC), 4-bit state codes.
//  - Sub-module mc_output_decode: purely combinational map of State and MemReady to control outputs.
//    The FSM register and next-state logic stay in multicycle_control.
// TESTING
//  - Reset held 3 cycles, then released -> all outputs 0 in IDLE, FETCH with MemRead=1 one cycle later.
//  - R-type Opcode=0000, MemReady always 1 -> states IDLE,FETCH,DECODE,EXEC_R(AluOp=10),R_WB(RegWrite=1,RegDst=1),FETCH.
//  - LW Opcode=0100, MemReady low 3 cycles in MEM_RD -> MemRead and IorD=1 held 4 cycles;
//    then MEM_WB with MemToReg=1, RegWrite=1.
//  - BEQ Opcode=1000, Zero=1 then Zero=0 on repeat -> BRANCH with AluOp=01, PCWriteCond=1, PCSource=01 both times; 3 cycles each.
//  - Opcode=1111 -> HALT, Halt=1 stays for 20 cycles; Reset pulse -> IDLE, Halt=0.
//  - Reset asserted during MEM_WR wait -> MemWrite=0 next cycle, state IDLE, no RegWrite or PCWrite pulse.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, AluOp codes,
// FSM state codes and the bundled control-word type.
package multicycle_control_pkg;

  localparam int OPW = 4;
  localparam logic [1:0] PC_INC_SEL = 2'b01;

  localparam logic [OPW-1:0] OP_R    = 4'b0000;
  localparam logic [OPW-1:0] OP_LW   = 4'b0100;
  localparam logic [OPW-1:0] OP_SW   = 4'b0101;
  localparam logic [OPW-1:0] OP_ADDI = 4'b0110;
  localparam logic [OPW-1:0] OP_BEQ  = 4'b1000;
  localparam logic [OPW-1:0] OP_J    = 4'b1010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_ADDI_EX  = 4'd9,
    ST_ADDI_WB  = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_HALT     = 4'd13
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halt;
  } ctrl_t;

  // Unknown opcodes land in HALT rather than executing something arbitrary.
  function automatic state_t dispatch(input logic [OPW-1:0] opcode);
    case (opcode)
      OP_R:         return ST_EXEC_R;
      OP_LW, OP_SW: return ST_MEM_ADDR;
      OP_ADDI:      return ST_ADDI_EX;
      OP_BEQ:       return ST_BRANCH;
      OP_J:         return ST_JUMP;
      default:      return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory (slave).
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           mem_read;
  logic           mem_write;
  logic           iord;
  logic           ir_write;
  logic           pc_write;
  logic           pc_write_cond;
  logic [1:0]     pc_source;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           halt;
  logic [3:0]     state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, halt, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, halt, state
  );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational control-word decode: Moore outputs from the state, plus the
// FETCH-only IR/PC loads that follow mem_ready directly.
module multicycle_control_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = PC_INC_SEL;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      // Speculative branch target computed while the opcode is dispatched.
      ST_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_ADDI_WB: ctrl.reg_write = 1'b1;
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      ST_HALT: ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle CPU: sequences fetch/decode/execute/
// memory/writeback and handshakes with unified memory via mem_read/mem_write/mem_ready.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Memory states stall until mem_ready; any unused encoding falls back to IDLE.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE:     next_state = ST_FETCH;
      ST_FETCH:    next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:   next_state = dispatch(bus.opcode);
      ST_EXEC_R:   next_state = ST_R_WB;
      ST_R_WB:     next_state = ST_FETCH;
      ST_MEM_ADDR: next_state = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   next_state = bus.mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   next_state = ST_FETCH;
      ST_MEM_WR:   next_state = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_ADDI_EX:  next_state = ST_ADDI_WB;
      ST_ADDI_WB:  next_state = ST_FETCH;
      ST_BRANCH:   next_state = ST_FETCH;
      ST_JUMP:     next_state = ST_FETCH;
      ST_HALT:     next_state = ST_HALT;
      default:     next_state = ST_IDLE;
    endcase
  end

  multicycle_control_output_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.iord          = ctrl.iord;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.halt          = ctrl.halt;
  assign bus.state         = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table plus hand-written
// sequences for HALT and reset during a memory-write wait.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, halt;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       mr;
    logic       z;
    outs_t      exp;
    string      name;
  } vec_t;

  typedef struct {
    string name;
    outs_t exp;
  } sb_t;

  localparam logic [3:0] OPC_R = 4'b0000, OPC_LW = 4'b0100, OPC_SW = 4'b0101;
  localparam logic [3:0] OPC_ADDI = 4'b0110, OPC_BEQ = 4'b1000, OPC_J = 4'b1010, OPC_BAD = 4'b1111;

  localparam outs_t O_IDLE     = '0;
  localparam outs_t O_FETCH_W  = '{st:4'd1, mem_read:1'b1, alu_src_b:2'b01, default:'0};
  localparam outs_t O_FETCH_R  = '{st:4'd1, mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1, pc_write:1'b1, default:'0};
  localparam outs_t O_DECODE   = '{st:4'd2, alu_src_b:2'b11, default:'0};
  localparam outs_t O_EXEC_R   = '{st:4'd3, alu_src_a:1'b1, alu_op:2'b10, default:'0};
  localparam outs_t O_R_WB     = '{st:4'd4, reg_write:1'b1, reg_dst:1'b1, default:'0};
  localparam outs_t O_MEM_ADDR = '{st:4'd5, alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam outs_t O_MEM_RD   = '{st:4'd6, mem_read:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_MEM_WB   = '{st:4'd7, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
  localparam outs_t O_MEM_WR   = '{st:4'd8, mem_write:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_ADDI_EX  = '{st:4'd9, alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam outs_t O_ADDI_WB  = '{st:4'd10, reg_write:1'b1, default:'0};
  localparam outs_t O_BRANCH   = '{st:4'd11, alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1, pc_source:2'b01, default:'0};
  localparam outs_t O_JUMP     = '{st:4'd12, pc_write:1'b1, pc_source:2'b10, default:'0};
  localparam outs_t O_HALT     = '{st:4'd13, halt:1'b1, default:'0};

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];
  sb_t  sb[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample_dut();
    outs_t a;
    a.st            = bus.state;
    a.mem_read      = bus.mem_read;
    a.mem_write     = bus.mem_write;
    a.iord          = bus.iord;
    a.ir_write      = bus.ir_write;
    a.pc_write      = bus.pc_write;
    a.pc_write_cond = bus.pc_write_cond;
    a.pc_source     = bus.pc_source;
    a.alu_src_a     = bus.alu_src_a;
    a.alu_src_b     = bus.alu_src_b;
    a.alu_op        = bus.alu_op;
    a.reg_dst       = bus.reg_dst;
    a.mem_to_reg    = bus.mem_to_reg;
    a.reg_write     = bus.reg_write;
    a.halt          = bus.halt;
    return a;
  endfunction

  task automatic addVec(input logic r, input logic [3:0] op, input logic mr, input logic z,
                        input outs_t e, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.z = z; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    sb_t   item;
    outs_t act;
    item = sb.pop_front();
    act  = sample_dut();
    checks++;
    if (act !== item.exp) begin
      failures++;
      $display("[TB] FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
               item.name, act.st, act[16:0], item.exp.st, item.exp[16:0]);
    end
  endtask

  // Inputs are applied just after a sample point and held through the next edge and sample.
  task automatic applyStimulus(input logic r, input logic [3:0] op, input logic mr, input logic z,
                               input outs_t e, input string nm);
    sb_t item;
    rst           = r;
    bus.opcode    = op;
    bus.mem_ready = mr;
    bus.zero      = z;
    item.name = nm;
    item.exp  = e;
    sb.push_back(item);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;

    for (int i = 0; i < 3; i++) addVec(1, OPC_R, 0, 0, O_IDLE, "reset_idle");
    addVec(0, OPC_R, 1, 0, O_FETCH_R, "first_fetch");
    addVec(0, OPC_R, 1, 0, O_DECODE, "r_decode");
    addVec(0, OPC_R, 1, 0, O_EXEC_R, "r_exec");
    addVec(0, OPC_R, 1, 0, O_R_WB, "r_wb");
    addVec(0, OPC_LW, 1, 0, O_FETCH_R, "lw_fetch");
    addVec(0, OPC_LW, 1, 0, O_DECODE, "lw_decode");
    addVec(0, OPC_LW, 0, 0, O_MEM_ADDR, "lw_addr");
    for (int i = 0; i < 4; i++) addVec(0, OPC_LW, 0, 0, O_MEM_RD, "lw_mem_wait");
    addVec(0, OPC_LW, 1, 0, O_MEM_WB, "lw_wb");
    addVec(0, OPC_BEQ, 1, 1, O_FETCH_R, "beq1_fetch");
    addVec(0, OPC_BEQ, 1, 1, O_DECODE, "beq1_decode");
    addVec(0, OPC_BEQ, 1, 1, O_BRANCH, "beq1_branch");
    addVec(0, OPC_BEQ, 1, 0, O_FETCH_R, "beq0_fetch");
    addVec(0, OPC_BEQ, 1, 0, O_DECODE, "beq0_decode");
    addVec(0, OPC_BEQ, 1, 0, O_BRANCH, "beq0_branch");
    addVec(0, OPC_ADDI, 1, 0, O_FETCH_R, "addi_fetch");
    addVec(0, OPC_ADDI, 1, 0, O_DECODE, "addi_decode");
    addVec(0, OPC_ADDI, 1, 0, O_ADDI_EX, "addi_exec");
    addVec(0, OPC_ADDI, 1, 0, O_ADDI_WB, "addi_wb");
    addVec(0, OPC_J, 1, 0, O_FETCH_R, "j_fetch");
    addVec(0, OPC_J, 1, 0, O_DECODE, "j_decode");
    addVec(0, OPC_J, 1, 0, O_JUMP, "j_jump");
    addVec(0, OPC_SW, 1, 0, O_FETCH_R, "sw_fetch");
    addVec(0, OPC_SW, 1, 0, O_DECODE, "sw_decode");
    addVec(0, OPC_SW, 1, 0, O_MEM_ADDR, "sw_addr");
    addVec(0, OPC_SW, 1, 0, O_MEM_WR, "sw_mem_zero_wait");
    addVec(0, OPC_BAD, 1, 0, O_FETCH_R, "bad_fetch");
    addVec(0, OPC_BAD, 0, 0, O_FETCH_W, "fetch_wait1");
    addVec(0, OPC_BAD, 0, 0, O_FETCH_W, "fetch_wait2");
    addVec(0, OPC_BAD, 1, 0, O_DECODE, "bad_decode");
    addVec(0, OPC_BAD, 0, 0, O_HALT, "halt_enter");

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].z, vecs[i].exp, vecs[i].name);

    // HALT is sticky regardless of memory or opcode activity.
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), O_HALT, "halt_hold");
    applyStimulus(1, OPC_SW, 1, 0, O_IDLE, "halt_reset");

    // Reset arriving while a store is stalled on memory.
    applyStimulus(0, OPC_SW, 1, 0, O_FETCH_R, "sw2_fetch");
    applyStimulus(0, OPC_SW, 1, 0, O_DECODE, "sw2_decode");
    applyStimulus(0, OPC_SW, 0, 0, O_MEM_ADDR, "sw2_addr");
    applyStimulus(0, OPC_SW, 0, 0, O_MEM_WR, "sw2_wait1");
    applyStimulus(0, OPC_SW, 0, 0, O_MEM_WR, "sw2_wait2");
    applyStimulus(1, OPC_SW, 0, 0, O_IDLE, "sw2_reset_mid_wait");
    applyStimulus(1, OPC_SW, 1, 0, O_IDLE, "sw2_reset_ready");
    applyStimulus(0, OPC_SW, 0, 0, O_FETCH_W, "sw2_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
